// File: rtl/aes256_decrypt_core.sv
// aes256_decrypt_core
//   Iterative AES-256 block decryptor (FIPS-197 inverse cipher). The 256-bit
//   key is expanded into 15 round keys, which are then applied in reverse
//   order. The datapath performs one primitive step per clock.
//
// Ports
//   clk        clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   in_valid   data_in/key valid
//   in_ready   core idle, accepts a block
//   data_in    ciphertext; [127:120] = state byte 0 (column-major, FIPS order)
//   key        cipher key; [255:248] = key byte 0
//   out_valid  data_out holds plaintext
//   out_ready  consumer accepts data_out
//   data_out   plaintext, same byte order as data_in
//
// Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. in_ready is high only while idle. data_in/key are sampled
//   only on the accepting edge. out_valid/data_out stay stable until the
//   edge where out_ready is high.
//
// Parameter KEY_CACHE: 1 skips key expansion when the key matches the last
//   fully expanded key; 0 always expands.

module aes256_decrypt_core #(
    parameter int KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [255:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEYEXP = 3'd1,
        INIT   = 3'd2,
        ROUND  = 3'd3,
        FINAL  = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Forward S-box, used only by the key schedule.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse S-box, used by the round datapath.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // ------------------------------------------------------------------
    // Primitive functions
    // ------------------------------------------------------------------
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Rcon for round-key pair index 1..7.
    function automatic logic [7:0] rcon(input logic [2:0] idx);
        logic [7:0] r;
        case (idx)
            3'd1:    r = 8'h01;
            3'd2:    r = 8'h02;
            3'd3:    r = 8'h04;
            3'd4:    r = 8'h08;
            3'd5:    r = 8'h10;
            3'd6:    r = 8'h20;
            3'd7:    r = 8'h40;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_9(input logic [7:0] a);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(a)));
        return x8 ^ a;
    endfunction

    function automatic logic [7:0] mul_b(input logic [7:0] a);
        logic [7:0] x2, x8;
        x2 = xtime(a);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ a;
    endfunction

    function automatic logic [7:0] mul_d(input logic [7:0] a);
        logic [7:0] x4, x8;
        x4 = xtime(xtime(a));
        x8 = xtime(x4);
        return x8 ^ x4 ^ a;
    endfunction

    function automatic logic [7:0] mul_e(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // State byte n (n = row + 4*col) lives at bits [8*(15-n) +: 8].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c+4-r)%4))) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            o[8*n +: 8] = INV_SBOX[s[8*n +: 8]];
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(15-4*c) +: 8];
            a1 = s[8*(14-4*c) +: 8];
            a2 = s[8*(13-4*c) +: 8];
            a3 = s[8*(12-4*c) +: 8];
            o[8*(15-4*c) +: 8] = mul_e(a0) ^ mul_b(a1) ^ mul_d(a2) ^ mul_9(a3);
            o[8*(14-4*c) +: 8] = mul_9(a0) ^ mul_e(a1) ^ mul_b(a2) ^ mul_d(a3);
            o[8*(13-4*c) +: 8] = mul_d(a0) ^ mul_9(a1) ^ mul_e(a2) ^ mul_b(a3);
            o[8*(12-4*c) +: 8] = mul_b(a0) ^ mul_d(a1) ^ mul_9(a2) ^ mul_e(a3);
        end
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t         state, state_nxt;
    logic [3:0]     kidx;         // round key being produced in KEYEXP (2..14)
    logic [3:0]     rnd;          // current inverse round (13..1)
    logic [1:0]     sub;          // sub-step within ROUND / FINAL
    logic           cache_valid;
    logic [255:0]   cache_key;
    logic [255:0]   key_reg;
    logic [127:0]   din_reg;
    logic [127:0]   st;
    logic [127:0]   rk [15];

    logic           accept;
    logic           cache_hit;
    logic [31:0]    last_w;
    logic [31:0]    ks_t;
    logic [31:0]    w0, w1, w2, w3;
    logic [127:0]   rk_m2;
    logic [127:0]   ks_next;
    logic [127:0]   step_rk;
    logic [127:0]   st_step;

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid && in_ready;
    // Full 256-bit compare; any difference forces a fresh expansion.
    assign cache_hit = (KEY_CACHE != 0) && cache_valid && (key == cache_key);

    // Key schedule: rk[kidx] from rk[kidx-1] and rk[kidx-2]. Even indices
    // start a new 8-word group (RotWord + Rcon), odd ones only SubWord.
    always_comb begin
        last_w = rk[kidx - 4'd1][31:0];
        rk_m2  = rk[kidx - 4'd2];
        if (!kidx[0]) begin
            ks_t = sub_word({last_w[23:0], last_w[31:24]}) ^ {rcon(kidx[3:1]), 24'h0};
        end else begin
            ks_t = sub_word(last_w);
        end
        w0      = rk_m2[127:96] ^ ks_t;
        w1      = rk_m2[95:64]  ^ w0;
        w2      = rk_m2[63:32]  ^ w1;
        w3      = rk_m2[31:0]   ^ w2;
        ks_next = {w0, w1, w2, w3};
    end

    // One primitive step of the inverse round, selected by sub.
    always_comb begin
        step_rk = (state == FINAL) ? rk[0] : rk[rnd];
        case (sub)
            2'd0:    st_step = inv_shift_rows(st);
            2'd1:    st_step = inv_sub_bytes(st);
            2'd2:    st_step = st ^ step_rk;
            default: st_step = inv_mix_columns(st);
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = cache_hit ? INIT : KEYEXP;
            KEYEXP:  if (kidx == 4'd14) state_nxt = INIT;
            INIT:    state_nxt = ROUND;
            ROUND:   if (sub == 2'd3 && rnd == 4'd1) state_nxt = FINAL;
            FINAL:   if (sub == 2'd2) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control state, outputs and cache flag; cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            kidx        <= 4'd2;
            rnd         <= 4'd13;
            sub         <= 2'd0;
            out_valid   <= 1'b0;
            data_out    <= '0;
            cache_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        kidx <= 4'd2;
                        sub  <= 2'd0;
                    end
                end
                KEYEXP: begin
                    kidx <= kidx + 4'd1;
                    if (kidx == 4'd14) cache_valid <= 1'b1;
                end
                INIT: begin
                    rnd <= 4'd13;
                    sub <= 2'd0;
                end
                ROUND: begin
                    sub <= sub + 2'd1;
                    if (sub == 2'd3 && rnd != 4'd1) rnd <= rnd - 4'd1;
                end
                FINAL: begin
                    if (sub == 2'd2) begin
                        data_out  <= st_step;
                        out_valid <= 1'b1;
                        sub       <= 2'd0;
                    end else begin
                        sub <= sub + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Datapath storage; contents are only meaningful once the control
    // state says so, so no reset is needed here.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (accept) begin
                    din_reg <= data_in;
                    key_reg <= key;
                    if (!cache_hit) begin
                        rk[0] <= key[255:128];
                        rk[1] <= key[127:0];
                    end
                end
            end
            KEYEXP: begin
                rk[kidx] <= ks_next;
                if (kidx == 4'd14) cache_key <= key_reg;
            end
            INIT:         st <= din_reg ^ rk[14];
            ROUND, FINAL: st <= st_step;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aes256_decrypt_core.sv
// tb_aes256_decrypt_core
//   Directed bench for aes256_decrypt_core. Instance dut uses the key cache,
//   dut_nc has it disabled. Known-answer vectors from FIPS-197 C.3 and
//   SP800-38A F.1.5.

module tb_aes256_decrypt_core;

    localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C1 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] C3 = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
    localparam logic [127:0] P3 = 128'h6bc1bee22e409f96e93d7e117393172a;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid_a, in_valid_b;
    logic         out_ready_a, out_ready_b;
    logic         in_ready_a, in_ready_b;
    logic         out_valid_a, out_valid_b;
    logic [127:0] data_out_a, data_out_b;
    logic [127:0] data_in;
    logic [255:0] key;

    logic         sel;   // 0: dut, 1: dut_nc
    logic         obs_in_ready, obs_out_valid;
    logic [127:0] obs_data_out;
    assign obs_in_ready  = sel ? in_ready_b  : in_ready_a;
    assign obs_out_valid = sel ? out_valid_b : out_valid_a;
    assign obs_data_out  = sel ? data_out_b  : data_out_a;

    aes256_decrypt_core #(.KEY_CACHE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .data_in   (data_in),
        .key       (key),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .data_out  (data_out_a)
    );

    aes256_decrypt_core #(.KEY_CACHE(0)) dut_nc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .data_in   (data_in),
        .key       (key),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .data_out  (data_out_b)
    );

    // ---------------- scoreboard ----------------
    int           checks   = 0;
    int           failures = 0;
    logic [127:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_in_valid(input logic v);
        if (sel) in_valid_b = v;
        else     in_valid_a = v;
    endtask

    task automatic drive_out_ready(input logic v);
        if (sel) out_ready_b = v;
        else     out_ready_a = v;
    endtask

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!obs_in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq({tag, "_in_ready"}, 128'(obs_in_ready), 128'(1));
    endtask

    // Sends one block, measures edges from accept to out_valid, checks the
    // plaintext, and optionally consumes it.
    task automatic send_block(input logic s, input logic [255:0] k, input logic [127:0] ct,
                              input logic [127:0] pt, input int exp_lat, input logic noise,
                              input logic keep_ready, input logic consume, input string tag);
        int lat;
        logic [127:0] exp;
        sel = s;
        wait_idle(tag);
        exp_q.push_back(pt);
        key  = k;
        data_in = ct;
        drive_in_valid(1'b1);
        if (keep_ready) drive_out_ready(1'b1);
        @(posedge clk);
        #1;
        drive_in_valid(1'b0);
        // Inputs must not be re-sampled after the accepting edge.
        data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        key     = {8{$urandom()}};
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (obs_out_valid) break;
            if (noise) begin
                drive_in_valid(1'($urandom_range(0, 1)));
                data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
                key     = {8{$urandom()}};
            end
        end
        drive_in_valid(1'b0);
        check_eq({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        exp = exp_q.pop_front();
        check_eq({tag, "_plaintext"}, obs_data_out, exp);
        if (consume) begin
            if (!keep_ready) begin
                @(negedge clk);
                drive_out_ready(1'b1);
            end
            @(posedge clk);
            #1;
            check_eq({tag, "_consumed_valid"}, 128'(obs_out_valid), 128'(0));
            check_eq({tag, "_back_idle"}, 128'(obs_in_ready), 128'(1));
            drive_out_ready(1'b0);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic hold_valid_ok, hold_data_ok;
        int   guard;

        rst_n       = 1'b0;
        sel         = 1'b0;
        in_valid_a  = 1'b0;
        in_valid_b  = 1'b0;
        out_ready_a = 1'b0;
        out_ready_b = 1'b0;
        data_in     = '0;
        key         = '0;
        #1;
        check_eq("rst_in_ready",  128'(in_ready_a),  128'(1));
        check_eq("rst_out_valid", 128'(out_valid_a), 128'(0));
        check_eq("rst_data_out",  data_out_a,        128'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // T1 expand, T2 cache hit, T3 new key, T1 again after cache overwrite
        send_block(1'b0, K1, C1, P1, 69, 1'b0, 1'b0, 1'b1, "t1");
        send_block(1'b0, K1, C1, P1, 56, 1'b0, 1'b0, 1'b1, "t2_hit");
        send_block(1'b0, K3, C3, P3, 69, 1'b0, 1'b0, 1'b1, "t3");
        send_block(1'b0, K1, C1, P1, 69, 1'b0, 1'b0, 1'b1, "t1_after_t3");

        // out_ready held high throughout, then in_valid noise while busy
        send_block(1'b0, K1, C1, P1, 56, 1'b0, 1'b1, 1'b1, "early_ready");
        send_block(1'b0, K1, C1, P1, 56, 1'b1, 1'b0, 1'b1, "in_noise");
        send_block(1'b0, K3, C3, P3, 69, 1'b1, 1'b0, 1'b1, "t3_noise");

        // T4: output held while out_ready stays low
        send_block(1'b0, K1, C1, P1, 69, 1'b0, 1'b0, 1'b0, "t4");
        hold_valid_ok = 1'b1;
        hold_data_ok  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!out_valid_a || in_ready_a) hold_valid_ok = 1'b0;
            if (data_out_a !== P1) hold_data_ok = 1'b0;
            in_valid_a = 1'($urandom_range(0, 1));
            data_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        check_eq("t4_hold_valid", 128'(hold_valid_ok), 128'(1));
        check_eq("t4_hold_data",  128'(hold_data_ok),  128'(1));
        @(negedge clk);
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t4_release_valid", 128'(out_valid_a), 128'(0));
        check_eq("t4_release_idle",  128'(in_ready_a),  128'(1));
        out_ready_a = 1'b0;

        // T5: cache holds K1 -> hit path; ROUND r=7 spans edges 26..29
        sel = 1'b0;
        @(negedge clk);
        guard = 0;
        while (!in_ready_a && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        key        = K1;
        data_in    = C1;
        in_valid_a = 1'b1;
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        repeat (27) @(posedge clk);
        #1;
        check_eq("t5_busy", 128'(in_ready_a), 128'(0));
        rst_n = 1'b0;
        #1;
        check_eq("t5_abort_valid", 128'(out_valid_a), 128'(0));
        check_eq("t5_abort_data",  data_out_a,        128'(0));
        check_eq("t5_abort_ready", 128'(in_ready_a),  128'(1));
        @(negedge clk);
        rst_n = 1'b1;
        send_block(1'b0, K1, C1, P1, 69, 1'b0, 1'b0, 1'b1, "t5_rerun");
        send_block(1'b0, K1, C1, P1, 56, 1'b0, 1'b0, 1'b1, "t5_rerun_hit");

        // KEY_CACHE=0 instance: repeated key still expands
        send_block(1'b1, K1, C1, P1, 69, 1'b0, 1'b0, 1'b1, "nc_t1");
        send_block(1'b1, K1, C1, P1, 69, 1'b0, 1'b0, 1'b1, "nc_t2");
        send_block(1'b1, K3, C3, P3, 69, 1'b0, 1'b0, 1'b1, "nc_t3");

        check_eq("exp_q_empty", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
